// File: rtl/timer_pkg.sv
// Shared state encoding and default timing for the countdown sequencer.
package timer_pkg;

   localparam int DEF_TICK_DIV = 100000000;
   localparam int DEF_PRE_W    = 27;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to the countdown tick rate; holds its count while en is low.
module tick_prescaler
   import timer_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int PRE_W    = DEF_PRE_W
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam logic [PRE_W-1:0] LAST = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0] count;

   assign tick = en && (count == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/countdown_ctrl.sv
// Start/pause/abort/timeout sequencer driving the down-counting timer chain.
module countdown_ctrl
   import timer_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int PRE_W    = DEF_PRE_W
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic pause_tgl,
   input  logic abort,
   input  logic cnt_zero,
   output logic cnt_set,
   output logic cnt_tick,
   output logic running,
   output logic paused,
   output logic expired,
   output logic timeout
);

   state_t state;
   state_t state_n;
   logic   set_n;
   logic   tick_n;
   logic   to_n;
   logic   pre_clr;
   logic   pre_en;
   logic   pre_tick;

   // A pause on the tick cycle freezes the prescaler at its last value,
   // so the dropped tick fires on the first cycle after resume.
   assign pre_clr = abort || start || (state == ST_LOAD);
   assign pre_en  = (state == ST_RUN) && !abort && !start && !pause_tgl;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV),
      .PRE_W    (PRE_W)
   ) u_pre (
      .clk  (clk),
      .rst  (rst),
      .clr  (pre_clr),
      .en   (pre_en),
      .tick (pre_tick)
   );

   always_comb begin
      state_n = state;
      set_n   = 1'b0;
      tick_n  = 1'b0;
      to_n    = 1'b0;
      if (abort) begin
         state_n = ST_IDLE;
      end else if (start) begin
         state_n = ST_LOAD;
         set_n   = 1'b1;
      end else begin
         unique case (state)
            ST_IDLE: state_n = ST_IDLE;
            ST_LOAD: state_n = ST_RUN;
            ST_RUN: begin
               if (pause_tgl) begin
                  state_n = ST_PAUSE;
               end else if (pre_tick) begin
                  // Never decrement past zero: expire instead.
                  if (cnt_zero) begin
                     state_n = ST_DONE;
                     to_n    = 1'b1;
                  end else begin
                     tick_n = 1'b1;
                  end
               end
            end
            ST_PAUSE: begin
               if (pause_tgl) begin
                  state_n = ST_RUN;
               end
            end
            ST_DONE: state_n = ST_DONE;
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt_set  <= 1'b0;
         cnt_tick <= 1'b0;
         timeout  <= 1'b0;
         running  <= 1'b0;
         paused   <= 1'b0;
         expired  <= 1'b0;
      end else begin
         state    <= state_n;
         cnt_set  <= set_n;
         cnt_tick <= tick_n;
         timeout  <= to_n;
         running  <= (state_n == ST_RUN);
         paused   <= (state_n == ST_PAUSE);
         expired  <= (state_n == ST_DONE);
      end
   end

endmodule
